// File: rtl/kv_seg_add.sv
// kv_seg_add: carry-pipelined add/subtract split into SEGS segments, valid/ready handshake.
// Optional carry-out port is enabled by defining KV_SEG_ADD_COUT_EN.
module kv_seg_add #(
  parameter int unsigned EW   = 32,
  parameter int unsigned SEGS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] s
`ifdef KV_SEG_ADD_COUT_EN
  ,
  output logic          cout
`endif
);

  localparam int unsigned SW = EW / SEGS;

  logic          stall;
  logic          adv;
  logic [EW-1:0] b_eff;

  if (SEGS < 1 || SEGS > EW || (EW % SEGS) != 0) begin : g_bad_cfg
    $error("kv_seg_add: SEGS must lie in 1..EW and divide EW");
  end

  // The whole pipeline freezes while the output register holds an unaccepted result.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    localparam int unsigned REM_W = EW - k * SW;     // operand bits not yet summed
    localparam int unsigned SUM_W = (k + 1) * SW;    // sum bits completed after this stage

    logic [REM_W-1:0] a_rem;
    logic [REM_W-1:0] b_rem;
    logic             v_in;
    logic             c_in;
    logic             c_d;
    logic [SW-1:0]    seg_d;
    logic [SUM_W-1:0] sum_d;
    logic             v_q;
    logic [SUM_W-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_rem = a;
      assign b_rem = b_eff;
      assign c_in  = sub;
      assign v_in  = in_valid;
      assign sum_d = seg_d;
    end else begin : g_src
      assign a_rem = g_stg[k-1].g_fwd.a_q;
      assign b_rem = g_stg[k-1].g_fwd.b_q;
      assign c_in  = g_stg[k-1].g_fwd.c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign sum_d = {seg_d, g_stg[k-1].sum_q};
    end

    assign {c_d, seg_d} = {1'b0, a_rem[SW-1:0]} + {1'b0, b_rem[SW-1:0]} + {{SW{1'b0}}, c_in};

    // Valid bit plus de-skewed partial sum; the last stage's sum_q is the s output.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        sum_q <= sum_d;
      end
    end

    if (k < SEGS - 1) begin : g_fwd
      logic [REM_W-SW-1:0] a_q;
      logic [REM_W-SW-1:0] b_q;
      logic                c_q;

      // Skew upper operand bits and the segment carry toward the next stage.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_rem[REM_W-1:SW];
          b_q <= b_rem[REM_W-1:SW];
          c_q <= c_d;
        end
      end
    end else begin : g_last
`ifdef KV_SEG_ADD_COUT_EN
      logic cout_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          cout_q <= 1'b0;
        end else if (adv) begin
          cout_q <= c_d;
        end
      end
`else
      // Final carry has no consumer in this build.
      logic unused_cout;
      assign unused_cout = c_d;
`endif
    end
  end

  assign out_valid = g_stg[SEGS-1].v_q;
  assign s         = g_stg[SEGS-1].sum_q;
`ifdef KV_SEG_ADD_COUT_EN
  assign cout      = g_stg[SEGS-1].g_last.cout_q;
`endif

endmodule

// File: tb/tb_kv_seg_add.sv
// Self-checking bench for kv_seg_add (EW=32, SEGS=4): vector table, scoreboard monitor,
// and hand-written stall, reset-flush and bubble sequences.
`timescale 1ns/1ps
module tb_kv_seg_add;
  localparam int unsigned EW   = 32;
  localparam int unsigned SEGS = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
`ifdef KV_SEG_ADD_COUT_EN
  logic        cout;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_in    = 0;
  int   n_out   = 0;
  exp_t sb[$];
  int   out_cyc[$];
  exp_t mon_e;

  kv_seg_add #(.EW(EW), .SEGS(SEGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
`ifdef KV_SEG_ADD_COUT_EN
    ,
    .cout      (cout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic msub);
    logic [31:0] bx;
    bx = msub ? ~mb : mb;
    return {1'b0, ma} + {1'b0, bx} + {32'd0, msub};
  endfunction

  // Scoreboard: every delivered result is matched against the oldest accepted operand set.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got s=0x%0h, expected no result", s);
      end else begin
        mon_e = sb.pop_front();
        check("result_s", 64'(s), 64'(mon_e.s));
`ifdef KV_SEG_ADD_COUT_EN
        check("result_cout", 64'(cout), 64'(mon_e.c));
`endif
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] ob, input logic ts,
                      input exp_t e);
    int w;
    w        = 0;
    a        = ta;
    b        = ob;
    sub      = ts;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", w);
    end else begin
      sb.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [31:0] ta, input logic [31:0] ob, input logic ts);
    logic [32:0] r;
    exp_t        e;
    r   = model(ta, ob, ts);
    e.s = r[31:0];
    e.c = r[32];
    send(ta, ob, ts, e);
  endtask

  task automatic measure_latency(input string name);
    int lat;
    lat      = 0;
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    check(name, 64'(lat), 64'd4);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[8];
    int          base;
    int          bad;
    logic [31:0] held;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vt[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1};
    vt[3] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0002_0000, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vt[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0};
    vt[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    check("post_reset_s", 64'(s), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
`ifdef KV_SEG_ADD_COUT_EN
    check("post_reset_cout", 64'(cout), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, each with a latency check.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].b, vt[i].sub, '{vt[i].s, vt[i].c});
      measure_latency("vector_latency");
      drain();
    end

    // Back-to-back random stream.
    out_cyc.delete();
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      logic [32:0] r;
      ra       = $urandom();
      rb       = $urandom();
      rs       = 1'($urandom_range(0, 1));
      r        = model(ra, rb, rs);
      a        = ra;
      b        = rb;
      sub      = rs;
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      sb.push_back('{r[31:0], r[32]});
      n_in++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 64'(n_out - base), 64'd16);
    bad = 0;
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) bad++;
    check("stream_gaps", 64'(bad), 64'd0);

    // Output stall with three results queued and a fourth operand waiting.
    base      = n_out;
    out_ready = 1'b0;
    send_m(32'h0000_00FF, 32'h0000_0001, 1'b0);
    send_m(32'h0100_0000, 32'h0000_0001, 1'b1);
    send_m(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    in_valid = 1'b0;
    bad      = 0;
    do begin
      @(negedge clk);
      bad++;
    end while (out_valid !== 1'b1 && bad < 20);
    check("stall_first_valid", 64'(out_valid), 64'd1);
    held     = s;
    a        = 32'hCAFE_0001;
    b        = 32'h0000_FFFF;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("stall_s_stable", 64'(s), 64'(held));
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_m(32'hCAFE_0001, 32'h0000_FFFF, 1'b0);
    in_valid = 1'b0;
    drain();
    check("stall_count", 64'(n_out - base), 64'd4);

    // Reset with three transactions in flight.
    send_m(32'h1111_1111, 32'h2222_2222, 1'b0);
    send_m(32'h3333_3333, 32'h4444_4444, 1'b1);
    send_m(32'h5555_5555, 32'h6666_6666, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    base = n_out;
    bad  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("flush_out_valid_cycles", 64'(bad), 64'd0);
    check("flush_no_output", 64'(n_out - base), 64'd0);
    @(posedge clk);
    #1;
    send(32'h0000_FFFF, 32'h0001_0001, 1'b0, '{32'h0002_0000, 1'b0});
    measure_latency("post_flush_latency");
    drain();

    // Alternating bubbles must keep their spacing at the output.
    out_cyc.delete();
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      send_m($urandom(), $urandom(), 1'(i % 2));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drain();
    check("alt_count", 64'(n_out - base), 64'd8);
    bad = 0;
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 2) bad++;
    check("alt_gaps", 64'(bad), 64'd0);
    check("total_in_out", 64'(n_out), 64'(n_in - 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
